// File: rtl/tlb_lookup_arbiter_if.sv
// Bus between the TLB lookup arbiter and its clients: the two miss-buffer
// requesters, the MEM-stage TLB instruction port, and the shared TLB search
// port. The arbiter connects through the slave modport; the environment uses
// the master modport.
interface tlb_lookup_arbiter_if #(
  parameter int VPN_W   = 19,
  parameter int ENTRY_W = 78
);
  // Requesters and MEM-stage instruction port
  logic               i_req;
  logic [VPN_W-1:0]   i_vpn2;
  logic               d_req;
  logic [VPN_W-1:0]   d_vpn2;
  logic               op_req;
  logic [1:0]         op_kind;
  logic               flush;
  // Shared TLB search/write port
  logic [VPN_W-1:0]   srch_vpn2;
  logic               srch_found;
  logic [ENTRY_W-1:0] srch_entry;
  logic [2:0]         srch_index;
  logic               tlbw_en;
  logic               tlbw_random;
  logic               tlbp_en;
  // Responses and status
  logic               i_resp_valid;
  logic               d_resp_valid;
  logic               resp_found;
  logic [ENTRY_W-1:0] resp_entry;
  logic               op_done;
  logic               busy;

  modport slave (
    input  i_req, i_vpn2, d_req, d_vpn2, op_req, op_kind, flush,
    input  srch_found, srch_entry, srch_index,
    output srch_vpn2, tlbw_en, tlbw_random, tlbp_en,
    output i_resp_valid, d_resp_valid, resp_found, resp_entry, op_done, busy
  );

  modport master (
    output i_req, i_vpn2, d_req, d_vpn2, op_req, op_kind, flush,
    output srch_found, srch_entry, srch_index,
    input  srch_vpn2, tlbw_en, tlbw_random, tlbp_en,
    input  i_resp_valid, d_resp_valid, resp_found, resp_entry, op_done, busy
  );
endinterface

// File: rtl/tlb_lookup_arbiter.sv
// TLB lookup arbiter: shares one TLB search port between the I-side and
// D-side miss buffers and the MEM-stage TLB instructions (TLBP/TLBWI/TLBWR).
// Lookup: IDLE (grant) -> LOOKUP (search) -> RESP (one-cycle response pulse).
// Instruction: IDLE (grant) -> OP (one-cycle strobe) -> IDLE with op_done.
// Optional feature macro: TLBARB_RR_EN -- round-robin between simultaneous
// I/D requests; without it D has fixed priority over I.
// VPN_W/ENTRY_W must match the parameters of the connected interface.
module tlb_lookup_arbiter #(
  parameter int VPN_W   = 19,
  parameter int ENTRY_W = 78
) (
  input  logic                    clk,
  input  logic                    rst,
  tlb_lookup_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_RESP   = 2'd2,
    S_OP     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_id_d;      // 1 = D-side owns the in-flight lookup
  logic [VPN_W-1:0]   r_vpn2;
  logic [1:0]         r_op_kind;
  logic               r_found;
  logic [ENTRY_W-1:0] r_entry;
  logic               r_op_done;

  logic               w_grant_i;
  logic               w_grant_d;
  logic               w_op_go;
  logic               w_lk_go;

  logic [VPN_W-1:0]   w_srch_vpn2;
  logic               w_tlbw_en;
  logic               w_tlbw_random;
  logic               w_tlbp_en;
  logic               w_i_resp_valid;
  logic               w_d_resp_valid;

  // The hit index is not needed here: the entry itself is returned.
  logic               w_unused_idx;
  assign w_unused_idx = ^bus.srch_index;

  // An op_req still high while op_done is showing belongs to the instruction
  // that just completed; granting it again would execute the write twice.
  assign w_op_go = (r_state == S_IDLE) && bus.op_req && !r_op_done;
  assign w_lk_go = (r_state == S_IDLE) && !w_op_go && (bus.i_req || bus.d_req);

`ifdef TLBARB_RR_EN
  logic r_last_i;  // 1 = I-side got the most recent lookup grant

  assign w_grant_d = bus.d_req && (!bus.i_req ||  r_last_i);
  assign w_grant_i = bus.i_req && (!bus.d_req || !r_last_i);

  // Remember which side won the last lookup grant so a tie alternates.
  always_ff @(posedge clk) begin
    if (rst)          r_last_i <= 1'b1;
    else if (w_lk_go) r_last_i <= w_grant_i;
  end
`else
  assign w_grant_d = bus.d_req;
  assign w_grant_i = bus.i_req && !bus.d_req;
`endif

  // State register plus the lookup/instruction latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_id_d    <= 1'b0;
      r_vpn2    <= '0;
      r_op_kind <= 2'b00;
      r_found   <= 1'b0;
      r_entry   <= '0;
      r_op_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_done <= (r_state == S_OP);
      if (w_op_go) r_op_kind <= bus.op_kind;
      if (w_lk_go) begin
        r_id_d <= w_grant_d;
        r_vpn2 <= w_grant_d ? bus.d_vpn2 : bus.i_vpn2;
      end
      // Flushed lookups never reach RESP, so their result is not kept.
      if (r_state == S_LOOKUP && !bus.flush) begin
        r_found <= bus.srch_found;
        r_entry <= bus.srch_entry;
      end
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_srch_vpn2    = bus.d_vpn2;
    w_tlbw_en      = 1'b0;
    w_tlbw_random  = 1'b0;
    w_tlbp_en      = 1'b0;
    w_i_resp_valid = 1'b0;
    w_d_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_op_go)      w_state_nxt = S_OP;
        else if (w_lk_go) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        w_srch_vpn2 = r_vpn2;
        w_state_nxt = bus.flush ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        w_i_resp_valid = !bus.flush && !r_id_d;
        w_d_resp_valid = !bus.flush &&  r_id_d;
        w_state_nxt    = S_IDLE;
      end
      S_OP: begin
        // 00 TLBP, 01 TLBWI, 10 TLBWR, 11 reserved (completes silently)
        w_tlbp_en     = (r_op_kind == 2'b00);
        w_tlbw_en     = (r_op_kind == 2'b01) || (r_op_kind == 2'b10);
        w_tlbw_random = (r_op_kind == 2'b10);
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.srch_vpn2    = w_srch_vpn2;
  assign bus.tlbw_en      = w_tlbw_en;
  assign bus.tlbw_random  = w_tlbw_random;
  assign bus.tlbp_en      = w_tlbp_en;
  assign bus.i_resp_valid = w_i_resp_valid;
  assign bus.d_resp_valid = w_d_resp_valid;
  assign bus.resp_found   = r_found;
  assign bus.resp_entry   = r_entry;
  assign bus.op_done      = r_op_done;
  assign bus.busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed bench for tlb_lookup_arbiter with a small 8-entry TLB model
// answering the shared search port.
module tb_tlb_lookup_arbiter;
  localparam int VPN_W   = 19;
  localparam int ENTRY_W = 78;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  tlb_lookup_arbiter_if #(.VPN_W(VPN_W), .ENTRY_W(ENTRY_W)) bus ();

  tlb_lookup_arbiter #(.VPN_W(VPN_W), .ENTRY_W(ENTRY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VPN_W-1:0] vpn_of(input int k);
    case (k)
      0: vpn_of = 19'h00001;
      1: vpn_of = 19'h00010;
      2: vpn_of = 19'h00100;
      3: vpn_of = 19'h01000;
      4: vpn_of = 19'h10000;
      5: vpn_of = 19'h00400;
      6: vpn_of = 19'h00800;
      default: vpn_of = 19'h7F000;
    endcase
  endfunction

  // {VPN2, ASID, G, PFN0, C0, D0, V0, PFN1, C1, D1, V1}
  function automatic logic [ENTRY_W-1:0] ent_of(input int k);
    ent_of = {vpn_of(k), 8'h3C, 1'b0, 20'hA0000 + 20'(k), 3'd3, 1'b1, 1'b1,
              20'hB0000 + 20'(k), 3'd2, 1'b0, 1'b1};
  endfunction

  // TLB model: fully associative match on the search VPN2.
  always_comb begin
    bus.srch_found = 1'b0;
    bus.srch_entry = '0;
    bus.srch_index = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (vpn_of(k) == bus.srch_vpn2) begin
        bus.srch_found = 1'b1;
        bus.srch_entry = ent_of(k);
        bus.srch_index = 3'(k);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    n_chk++; if ({bus.i_resp_valid, bus.d_resp_valid, bus.op_done, bus.tlbw_en, bus.tlbp_en, bus.tlbw_random} !== 6'b0) begin
      n_err++; $display("FAIL reset_strobes got=%b exp=000000",
        {bus.i_resp_valid, bus.d_resp_valid, bus.op_done, bus.tlbw_en, bus.tlbp_en, bus.tlbw_random}); end
    n_chk++; if (bus.resp_found !== 1'b0 || bus.resp_entry !== '0) begin
      n_err++; $display("FAIL reset_resp got=%0b/%h exp=0/0", bus.resp_found, bus.resp_entry); end
    rst = 1'b0;
    bus.d_vpn2 = 19'h00123;
    tick();
    n_chk++; if (bus.srch_vpn2 !== 19'h00123) begin n_err++; $display("FAIL idle_srch_vpn2 got=%h exp=00123", bus.srch_vpn2); end
  endtask

  task automatic test_i_lookup();
    bus.i_req = 1'b1; bus.i_vpn2 = 19'h00400;
    tick();
    n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ilk_busy got=%0b exp=1", bus.busy); end
    n_chk++; if (bus.srch_vpn2 !== 19'h00400) begin n_err++; $display("FAIL ilk_srch_vpn2 got=%h exp=00400", bus.srch_vpn2); end
    n_chk++; if (bus.i_resp_valid !== 1'b0) begin n_err++; $display("FAIL ilk_early_valid got=%0b exp=0", bus.i_resp_valid); end
    tick();
    n_chk++; if (bus.i_resp_valid !== 1'b1 || bus.d_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL ilk_valid got=i%0b d%0b exp=i1 d0", bus.i_resp_valid, bus.d_resp_valid); end
    n_chk++; if (bus.resp_found !== 1'b1) begin n_err++; $display("FAIL ilk_found got=%0b exp=1", bus.resp_found); end
    n_chk++; if (bus.resp_entry !== ent_of(5)) begin n_err++; $display("FAIL ilk_entry got=%h exp=%h", bus.resp_entry, ent_of(5)); end
    bus.i_req = 1'b0;
    tick();
    n_chk++; if (bus.i_resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL ilk_after got=v%0b b%0b exp=v0 b0", bus.i_resp_valid, bus.busy); end
  endtask

  task automatic test_unmapped();
    bus.d_req = 1'b1; bus.d_vpn2 = 19'h12345;
    tick();
    tick();
    n_chk++; if (bus.d_resp_valid !== 1'b1) begin n_err++; $display("FAIL unmap_valid got=%0b exp=1", bus.d_resp_valid); end
    n_chk++; if (bus.resp_found !== 1'b0) begin n_err++; $display("FAIL unmap_found got=%0b exp=0", bus.resp_found); end
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_tie();
    logic [2:0] seq;
    logic [2:0] exp_seq;
    int         cnt;
    cnt = 0; seq = 3'b000;
`ifdef TLBARB_RR_EN
    exp_seq = 3'b101;  // D, I, D (bit0 first; 1 = D)
`else
    exp_seq = 3'b111;  // D, D, D
`endif
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_vpn2 = vpn_of(1);
    bus.d_req = 1'b1; bus.d_vpn2 = vpn_of(2);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 40 && cnt < 3; c++) begin
      tick();
      n_chk++; if (bus.i_resp_valid && bus.d_resp_valid) begin n_err++; $display("FAIL tie_both_valid got=11 exp=not both"); end
      if (bus.i_resp_valid || bus.d_resp_valid) begin
        seq[cnt] = bus.d_resp_valid;
        cnt++;
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    n_chk++; if (cnt !== 3) begin n_err++; $display("FAIL tie_timeout got=%0d exp=3 responses", cnt); end
    n_chk++; if (seq !== exp_seq) begin n_err++; $display("FAIL tie_order got=%b exp=%b", seq, exp_seq); end
    tick();
    tick();
  endtask

  task automatic test_op();
    bus.d_req = 1'b1; bus.d_vpn2 = vpn_of(3);
    bus.op_req = 1'b1; bus.op_kind = 2'b10;
    tick();
    n_chk++; if ({bus.tlbw_en, bus.tlbw_random, bus.tlbp_en} !== 3'b110) begin
      n_err++; $display("FAIL tlbwr_strobe got=%b exp=110", {bus.tlbw_en, bus.tlbw_random, bus.tlbp_en}); end
    n_chk++; if (bus.busy !== 1'b1 || bus.op_done !== 1'b0) begin
      n_err++; $display("FAIL tlbwr_busy got=b%0b d%0b exp=b1 d0", bus.busy, bus.op_done); end
    bus.op_req = 1'b0;
    tick();
    n_chk++; if (bus.op_done !== 1'b1 || bus.tlbw_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL tlbwr_done got=d%0b w%0b b%0b exp=d1 w0 b0", bus.op_done, bus.tlbw_en, bus.busy); end
    tick();
    n_chk++; if (bus.op_done !== 1'b0 || bus.srch_vpn2 !== vpn_of(3) || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL op_then_lookup got=d%0b v%h b%0b exp=d0 v%h b1", bus.op_done, bus.srch_vpn2, bus.busy, vpn_of(3)); end
    tick();
    n_chk++; if (bus.d_resp_valid !== 1'b1 || bus.resp_entry !== ent_of(3)) begin
      n_err++; $display("FAIL op_then_resp got=v%0b e%h exp=v1 e%h", bus.d_resp_valid, bus.resp_entry, ent_of(3)); end
    bus.d_req = 1'b0;
    tick();
    // TLBWI, TLBP, reserved: expected {tlbw_en, tlbw_random, tlbp_en}
    for (int k = 0; k < 3; k++) begin
      logic [1:0] kind;
      logic [2:0] exp_s;
      kind  = (k == 0) ? 2'b01 : (k == 1) ? 2'b00 : 2'b11;
      exp_s = (k == 0) ? 3'b100 : (k == 1) ? 3'b001 : 3'b000;
      bus.op_req = 1'b1; bus.op_kind = kind;
      tick();
      bus.op_req = 1'b0;
      n_chk++; if ({bus.tlbw_en, bus.tlbw_random, bus.tlbp_en} !== exp_s) begin
        n_err++; $display("FAIL op%b_strobe got=%b exp=%b", kind, {bus.tlbw_en, bus.tlbw_random, bus.tlbp_en}, exp_s); end
      tick();
      n_chk++; if (bus.op_done !== 1'b1 || {bus.tlbw_en, bus.tlbp_en} !== 2'b00) begin
        n_err++; $display("FAIL op%b_done got=d%0b s%b exp=d1 s00", kind, bus.op_done, {bus.tlbw_en, bus.tlbp_en}); end
      tick();
    end
  endtask

  task automatic test_flush();
    bus.d_req = 1'b1; bus.d_vpn2 = 19'h7FFFF;
    tick();
    n_chk++; if (bus.busy !== 1'b1 || bus.srch_vpn2 !== 19'h7FFFF) begin
      n_err++; $display("FAIL flush_lookup got=b%0b v%h exp=b1 v7ffff", bus.busy, bus.srch_vpn2); end
    bus.flush = 1'b1; bus.d_req = 1'b0;
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.d_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_lk_abort got=b%0b v%0b exp=b0 v0", bus.busy, bus.d_resp_valid); end
    bus.flush = 1'b0;
    tick();
    n_chk++; if (bus.d_resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_lk_late got=%0b exp=0", bus.d_resp_valid); end
    // flush arriving in RESP suppresses the pulse
    bus.d_req = 1'b1; bus.d_vpn2 = vpn_of(4);
    tick();
    tick();
    n_chk++; if (bus.d_resp_valid !== 1'b1) begin n_err++; $display("FAIL flush_resp_pre got=%0b exp=1", bus.d_resp_valid); end
    bus.flush = 1'b1; bus.d_req = 1'b0;
    #1;
    n_chk++; if (bus.d_resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_resp_sup got=%0b exp=0", bus.d_resp_valid); end
    tick();
    bus.flush = 1'b0;
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_resp_idle got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.i_req = 1'b1; bus.i_vpn2 = vpn_of(6);
    tick();
    bus.i_req = 1'b0;  // dropped after grant; lookup still completes
    bus.op_req = 1'b1; bus.op_kind = 2'b00;
    n_chk++; if (bus.tlbp_en !== 1'b0) begin n_err++; $display("FAIL b2b_lk_tlbp got=%0b exp=0", bus.tlbp_en); end
    tick();
    n_chk++; if (bus.i_resp_valid !== 1'b1 || bus.resp_entry !== ent_of(6) || bus.tlbp_en !== 1'b0) begin
      n_err++; $display("FAIL b2b_resp got=v%0b e%h p%0b exp=v1 e%h p0", bus.i_resp_valid, bus.resp_entry, bus.tlbp_en, ent_of(6)); end
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.tlbp_en !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle got=b%0b p%0b exp=b0 p0", bus.busy, bus.tlbp_en); end
    tick();
    n_chk++; if (bus.tlbp_en !== 1'b1) begin n_err++; $display("FAIL b2b_op got=%0b exp=1", bus.tlbp_en); end
    bus.op_req = 1'b0;
    tick();
    n_chk++; if (bus.op_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%0b exp=1", bus.op_done); end
    tick();
  endtask

  task automatic test_rst_resp();
    bus.i_req = 1'b1; bus.i_vpn2 = vpn_of(5);
    tick();
    tick();
    n_chk++; if (bus.i_resp_valid !== 1'b1 || bus.resp_found !== 1'b1) begin
      n_err++; $display("FAIL rst_resp_pre got=v%0b f%0b exp=v1 f1", bus.i_resp_valid, bus.resp_found); end
    rst = 1'b1; bus.i_req = 1'b0;
    tick();
    n_chk++; if ({bus.i_resp_valid, bus.d_resp_valid, bus.op_done, bus.tlbw_en, bus.tlbp_en, bus.tlbw_random, bus.busy, bus.resp_found} !== 8'b0) begin
      n_err++; $display("FAIL rst_resp_outs got=%b exp=00000000",
        {bus.i_resp_valid, bus.d_resp_valid, bus.op_done, bus.tlbw_en, bus.tlbp_en, bus.tlbw_random, bus.busy, bus.resp_found}); end
    n_chk++; if (bus.resp_entry !== '0) begin n_err++; $display("FAIL rst_resp_entry got=%h exp=0", bus.resp_entry); end
    rst = 1'b0;
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.i_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_resp_idle got=b%0b v%0b exp=b0 v0", bus.busy, bus.i_resp_valid); end
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_vpn2 = '0;
    bus.d_req = 1'b0; bus.d_vpn2 = '0;
    bus.op_req = 1'b0; bus.op_kind = 2'b00;
    bus.flush = 1'b0;
    test_reset();
    test_i_lookup();
    test_unmapped();
    test_tie();
    test_op();
    test_flush();
    test_back_to_back();
    test_rst_resp();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tlb_lookup_arbiter.md
TLB_LOOKUP_ARBITER -- requirements
Module: tlb_lookup_arbiter

Interface
REQ-001 SHALL have parameter VPN_W, default 19, meaning VPN2 width (bits 31:13).
REQ-002 SHALL have parameter ENTRY_W, default 78, meaning packed TLB entry width (VPN2, ASID, G, PFN0/C0/D0/V0, PFN1/C1/D1/V1).
REQ-003 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset): reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have ports i_req (in, 1, I-side buffer miss request, level) and i_vpn2 (in, VPN_W, I-side lookup VPN2).
REQ-005 SHALL have ports d_req (in, 1, D-side buffer miss request, level) and d_vpn2 (in, VPN_W, D-side lookup VPN2).
REQ-006 SHALL have ports op_req (in, 1, MEM-stage TLB instruction request) and op_kind (in, 2, 00 TLBP, 01 TLBWI, 10 TLBWR, 11 reserved).
REQ-007 SHALL have ports flush (in, 1, pipeline flush that discards in-flight lookups).
REQ-008 SHALL have ports srch_vpn2 (out, VPN_W, shared search-port VPN2), srch_found (in, 1, search hit), srch_entry (in, ENTRY_W, hit entry), srch_index (in, 3, hit index).
REQ-009 SHALL have ports tlbw_en (out, 1, TLB write strobe), tlbw_random (out, 1, 1 = random index, 0 = CP0 index), tlbp_en (out, 1, TLBP select on search port).
REQ-010 SHALL have ports i_resp_valid, d_resp_valid (out, 1 each, response pulses), resp_found (out, 1), resp_entry (out, ENTRY_W), op_done (out, 1), busy (out, 1).

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, RESP, OP.
REQ-012 SHALL, in IDLE, select op_req first, then a lookup requester by priority rule (REQ-029/030); no request stays in IDLE.
REQ-013 SHALL, on IDLE with op_req, enter OP for exactly one cycle, driving tlbp_en=1 for TLBP, or tlbw_en=1 with tlbw_random=op_kind[1] for TLBWI/TLBWR.
REQ-014 SHALL assert op_done for one cycle in the cycle after OP, returning to IDLE; reserved op_kind completes with no strobe.
REQ-015 SHALL, on IDLE grant of a lookup, latch requester ID and VPN2, enter LOOKUP, drive srch_vpn2 from the latch for that cycle.
REQ-016 SHALL register srch_found/srch_entry at end of LOOKUP and enter RESP.
REQ-017 SHALL, in RESP, pulse the granted requester's resp_valid for one cycle with registered resp_found/resp_entry, then return to IDLE.
REQ-018 SHALL give a lookup latency of exactly 2 cycles from IDLE-grant edge to resp_valid; requesters hold req and vpn2 until resp_valid.
REQ-019 SHALL ignore requester deassertion after grant; the lookup completes.
REQ-020 SHALL, on flush during LOOKUP or RESP, suppress resp_valid and return to IDLE next cycle; flush does not abort OP.
REQ-021 SHALL never preempt an in-flight lookup with op_req; op_req waits in IDLE.
REQ-022 SHALL drive srch_vpn2 from d_vpn2 when not in LOOKUP; tlbw_en/tlbp_en zero outside OP.
REQ-023 SHALL assert busy whenever state is not IDLE.
REQ-024 SHALL never assert i_resp_valid and d_resp_valid in the same cycle.

Reset
REQ-025 SHALL, on rst, force IDLE regardless of state, discarding in-flight lookup or op.
REQ-026 SHALL reset all outputs to 0: resp_valid pair, op_done, tlbw_en, tlbp_en, tlbw_random, busy, resp_found, resp_entry.
REQ-027 SHALL reset the round-robin last-grant flag to "I granted last" so D wins the first tie.

Configuration
REQ-028 SHALL use macro TLBARB_RR_EN.
REQ-029 SHALL, with TLBARB_RR_EN defined, arbitrate simultaneous i_req/d_req round-robin, granting the side not granted last; flag updates on every lookup grant.
REQ-030 SHALL, without TLBARB_RR_EN, give d_req fixed priority over i_req; flag logic absent.

Verification
REQ-031 SHALL cover: i_req=1, i_vpn2=0x00400 matched at index 5 -> i_resp_valid 2 cycles later, resp_found=1, resp_entry = entry 5.
REQ-032 SHALL cover: i_req and d_req both held from reset -> with RR, order D,I,D; without, D repeatedly until d_req drops.
REQ-033 SHALL cover: op_req=1, op_kind=10 with d_req=1 in IDLE -> OP first, tlbw_en=1 and tlbw_random=1 one cycle, op_done next cycle, then D lookup.
REQ-034 SHALL cover: flush during LOOKUP of d_vpn2=0x7FFFF -> no d_resp_valid, busy=0 next cycle.
REQ-035 SHALL cover: rst asserted in RESP -> next cycle all outputs 0, state IDLE, no resp_valid.
REQ-036 SHALL cover: unmapped VPN2 lookup -> resp_valid with resp_found=0.
